// File: rtl/dmac_pkg.sv
// Shared definitions for the DMAC APB configuration block: register
// offsets, the read-only version word and the bus-handshake state type.
package dmac_pkg;

    localparam logic [11:0] DMAC_VER    = 12'h000;
    localparam logic [11:0] DMAC_SRC    = 12'h100;
    localparam logic [11:0] DMAC_DST    = 12'h104;
    localparam logic [11:0] DMAC_LEN    = 12'h108;
    localparam logic [11:0] DMAC_CMD    = 12'h10C;
    localparam logic [11:0] DMAC_STATUS = 12'h110;

    localparam logic [31:0] DMAC_VERSION = 32'h0001_2024;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_t;

endpackage

// File: rtl/dmac_apb_cfg.sv
// APB slave register file for the DMAC: SRC/DST/LEN job registers, CMD
// write -> one-cycle start pulse, engine status readback.
// Optional feature macro: DMAC_APB_WAIT_EN inserts WAIT_CYCLES wait states
// into every access; without it every access is zero-wait.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | no transfer in progress; psel_i high starts the setup
// ST_ACCESS | access phase; counts down wait states, commits at cnt==0
module dmac_apb_cfg
    import dmac_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          LEN_W       = 16,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] VERSION     = DMAC_VERSION
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic              pwrite_i,
    input  logic [31:0]       pwdata_i,
    output logic              pready_o,
    output logic [31:0]       prdata_o,
    output logic              pslverr_o,
    output logic [31:0]       src_addr_o,
    output logic [31:0]       dst_addr_o,
    output logic [LEN_W-1:0]  byte_len_o,
    output logic              start_o,
    input  logic              done_i
);

`ifdef DMAC_APB_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    localparam int         WAIT_EFF  = WAIT_EN ? WAIT_CYCLES : 0;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_EFF);

    apb_state_t  state;
    apb_state_t  state_nxt;
    logic [3:0]  cnt;

    logic [11:0] offset;
    logic        mapped;
    logic        wr_legal;
    logic        acc_err;
    logic [31:0] rd_val;
    logic        wr_commit;

    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [LEN_W-1:0] len_q;

    // Only the low 12 address bits are decoded; the access-phase strobe is
    // implied by the FSM, so penable_i carries no extra information here.
    logic unused_sigs;
    assign unused_sigs = ^{penable_i, paddr_i[ADDR_W-1:12]};

    assign offset = paddr_i[11:0];

    // State register and wait-state counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && psel_i)
                cnt <= WAIT_LOAD;
            else if (state == ST_ACCESS && psel_i && cnt != 4'd0)
                cnt <= cnt - 4'd1;
        end
    end

    // Next-state: a dropped psel_i aborts the access without committing.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (psel_i) state_nxt = ST_ACCESS;
            ST_ACCESS: if (!psel_i || cnt == 4'd0) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: pready_o marks the commit cycle.
    always_comb begin
        pready_o = !rst && (state == ST_ACCESS) && psel_i && (cnt == 4'd0);
    end

    // Address decode, read mux source and access legality.
    always_comb begin
        mapped   = 1'b1;
        wr_legal = 1'b0;
        rd_val   = 32'd0;
        case (offset)
            DMAC_VER:    rd_val = VERSION;
            DMAC_SRC:    begin rd_val = src_q;        wr_legal = done_i; end
            DMAC_DST:    begin rd_val = dst_q;        wr_legal = done_i; end
            DMAC_LEN:    begin rd_val = 32'(len_q);   wr_legal = done_i; end
            DMAC_CMD:    wr_legal = done_i;
            DMAC_STATUS: rd_val = {31'd0, done_i};
            default:     mapped = 1'b0;
        endcase
        acc_err = !mapped || (pwrite_i && !wr_legal);
    end

    assign wr_commit = pready_o && pwrite_i && !acc_err;

    // Bus response: only meaningful during the commit cycle.
    always_comb begin
        pslverr_o = pready_o && acc_err;
        prdata_o  = (pready_o && !pwrite_i && !acc_err) ? rd_val : 32'd0;
    end

    // Job registers, written only by a legal committed write.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q <= 32'd0;
            dst_q <= 32'd0;
            len_q <= '0;
        end else if (wr_commit) begin
            case (offset)
                DMAC_SRC: src_q <= pwdata_i;
                DMAC_DST: dst_q <= pwdata_i;
                DMAC_LEN: len_q <= pwdata_i[LEN_W-1:0];
                default:  ;
            endcase
        end
    end

    // Start pulse: high for the single cycle after a CMD commit with bit0 set.
    always_ff @(posedge clk) begin
        if (rst)
            start_o <= 1'b0;
        else
            start_o <= wr_commit && (offset == DMAC_CMD) && pwdata_i[0];
    end

    assign src_addr_o = src_q;
    assign dst_addr_o = dst_q;
    assign byte_len_o = len_q;

endmodule

// File: tb/tb_dmac_apb_cfg.sv
// Self-checking bench for dmac_apb_cfg: directed scenarios plus randomized
// APB traffic checked against a register-map reference model.
module tb_dmac_apb_cfg;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic        pready, pslverr, start, done;
    logic [31:0] prdata, src_addr, dst_addr;
    logic [15:0] byte_len;

    int vectors = 0;
    int miscompares = 0;

`ifdef DMAC_APB_WAIT_EN
    localparam int EXP_WAITS = 2;
`else
    localparam int EXP_WAITS = 0;
`endif

    // reference model state
    logic [31:0] m_src, m_dst;
    logic [15:0] m_len;

    // results of the last transfer
    logic [31:0] x_rdata;
    logic        x_err, x_start_pre, x_start_post;
    int          x_waits;

    dmac_apb_cfg dut (
        .clk(clk), .rst(rst),
        .psel_i(psel), .penable_i(penable), .paddr_i(paddr),
        .pwrite_i(pwrite), .pwdata_i(pwdata),
        .pready_o(pready), .prdata_o(prdata), .pslverr_o(pslverr),
        .src_addr_o(src_addr), .dst_addr_o(dst_addr), .byte_len_o(byte_len),
        .start_o(start), .done_i(done)
    );

    always #5 clk = ~clk;

    // One APB transfer; keep=1 leaves psel high for a back-to-back follow-on.
    task automatic apb_xfer(input logic [31:0] addr, input logic wr,
                            input logic [31:0] wdata, input bit keep);
        int n;
        if (!psel) begin @(posedge clk); #1; end
        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        x_waits = 0; n = 0;
        while (!pready && n < 64) begin
            x_waits++; n++;
            @(posedge clk); #1;
        end
        if (!pready) begin
            vectors++; miscompares++;
            $display("FAIL xfer_timeout addr=%h pready never rose", addr);
            psel = 1'b0; penable = 1'b0;
            return;
        end
        x_rdata = prdata; x_err = pslverr; x_start_pre = start;
        @(posedge clk); #1;
        x_start_post = start;
        penable = 1'b0;
        if (!keep) psel = 1'b0;
    endtask

    // Register-map rules evaluated directly from the address/data/done level.
    function automatic void model(input logic [31:0] addr, input logic wr,
                                  input logic [31:0] wdata, input logic dn,
                                  output logic [31:0] e_rd, output logic e_err,
                                  output logic e_start);
        logic [11:0] off;
        bit is_mapped, is_writable;
        off = addr[11:0];
        is_mapped   = off inside {12'h000, 12'h100, 12'h104, 12'h108, 12'h10C, 12'h110};
        is_writable = off inside {12'h100, 12'h104, 12'h108, 12'h10C};
        e_rd = 32'd0; e_err = 1'b0; e_start = 1'b0;
        if (!is_mapped) e_err = 1'b1;
        else if (wr) begin
            if (!is_writable || !dn) e_err = 1'b1;
            else if (off == 12'h100) m_src = wdata;
            else if (off == 12'h104) m_dst = wdata;
            else if (off == 12'h108) m_len = wdata[15:0];
            else e_start = wdata[0];
        end else begin
            if (off == 12'h000) e_rd = 32'h0001_2024;
            else if (off == 12'h100) e_rd = m_src;
            else if (off == 12'h104) e_rd = m_dst;
            else if (off == 12'h108) e_rd = {16'd0, m_len};
            else if (off == 12'h110) e_rd = {31'd0, dn};
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({pready, pslverr, start} !== 3'b000 || prdata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got rdy/err/start=%b prdata=%h exp 000/0",
                     {pready, pslverr, start}, prdata);
        end
        vectors++;
        if (src_addr !== 32'd0 || dst_addr !== 32'd0 || byte_len !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_regs got %h %h %h exp zeros", src_addr, dst_addr, byte_len);
        end
        rst = 1'b0;
        m_src = 0; m_dst = 0; m_len = 0;
        apb_xfer(32'h000, 1'b0, 32'd0, 1'b0);
        vectors++;
        if (x_rdata !== 32'h0001_2024 || x_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ver got %h err=%b exp 00012024 err=0", x_rdata, x_err);
        end
        for (int i = 0; i < 3; i++) begin
            apb_xfer(32'h100 + 32'(4 * i), 1'b0, 32'd0, 1'b0);
            vectors++;
            if (x_rdata !== 32'd0 || x_err !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_reg%0d got %h err=%b exp 0 err=0", i, x_rdata, x_err);
            end
        end
    endtask

    task automatic test_rw();
        logic [31:0] wv [3];
        logic [31:0] ev [3];
        wv[0] = 32'h1000_0000; wv[1] = 32'h2000_0000; wv[2] = 32'h0000_0100;
        ev[0] = 32'h1000_0000; ev[1] = 32'h2000_0000; ev[2] = 32'h0000_0100;
        done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apb_xfer(32'h100 + 32'(4 * i), 1'b1, wv[i], 1'b0);
            vectors++;
            if (x_err !== 1'b0 || x_waits != EXP_WAITS) begin
                miscompares++;
                $display("FAIL rw_write%0d got err=%b waits=%0d exp 0/%0d", i, x_err, x_waits, EXP_WAITS);
            end
        end
        m_src = ev[0]; m_dst = ev[1]; m_len = ev[2][15:0];
        for (int i = 0; i < 3; i++) begin
            apb_xfer(32'h100 + 32'(4 * i), 1'b0, 32'd0, 1'b0);
            vectors++;
            if (x_rdata !== ev[i]) begin
                miscompares++;
                $display("FAIL rw_read%0d got %h exp %h", i, x_rdata, ev[i]);
            end
        end
        vectors++;
        if (src_addr !== ev[0] || dst_addr !== ev[1] || byte_len !== 16'h0100) begin
            miscompares++;
            $display("FAIL rw_outputs got %h %h %h exp %h %h 0100", src_addr, dst_addr, byte_len, ev[0], ev[1]);
        end
    endtask

    task automatic test_cmd();
        done = 1'b1;
        apb_xfer(32'h10C, 1'b1, 32'd1, 1'b0);
        vectors++;
        if (x_start_pre !== 1'b0 || x_start_post !== 1'b1 || x_err !== 1'b0) begin
            miscompares++;
            $display("FAIL cmd_pulse got pre=%b post=%b err=%b exp 0/1/0", x_start_pre, x_start_post, x_err);
        end
        @(posedge clk); #1;
        vectors++;
        if (start !== 1'b0) begin
            miscompares++;
            $display("FAIL cmd_pulse_width got start=%b one cycle later exp 0", start);
        end
        apb_xfer(32'h10C, 1'b1, 32'd0, 1'b0);
        vectors++;
        if (x_start_post !== 1'b0) begin
            miscompares++;
            $display("FAIL cmd_zero got start=%b exp 0", x_start_post);
        end
        apb_xfer(32'h10C, 1'b0, 32'd0, 1'b0);
        vectors++;
        if (x_rdata !== 32'd0 || x_err !== 1'b0) begin
            miscompares++;
            $display("FAIL cmd_read got %h err=%b exp 0 err=0", x_rdata, x_err);
        end
    endtask

    task automatic test_busy();
        done = 1'b0;
        apb_xfer(32'h100, 1'b1, 32'hDEAD_BEEF, 1'b0);
        vectors++;
        if (x_err !== 1'b1 || src_addr !== m_src) begin
            miscompares++;
            $display("FAIL busy_write got err=%b src=%h exp 1 %h", x_err, src_addr, m_src);
        end
        apb_xfer(32'h10C, 1'b1, 32'd1, 1'b0);
        vectors++;
        if (x_err !== 1'b1 || x_start_post !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_cmd got err=%b start=%b exp 1/0", x_err, x_start_post);
        end
        apb_xfer(32'h110, 1'b0, 32'd0, 1'b0);
        vectors++;
        if (x_rdata !== 32'd0 || x_err !== 1'b0) begin
            miscompares++;
            $display("FAIL status_busy got %h err=%b exp 0 err=0", x_rdata, x_err);
        end
        done = 1'b1;
        apb_xfer(32'h110, 1'b0, 32'd0, 1'b0);
        vectors++;
        if (x_rdata !== 32'd1) begin
            miscompares++;
            $display("FAIL status_idle got %h exp 1", x_rdata);
        end
    endtask

    task automatic test_errors();
        done = 1'b1;
        apb_xfer(32'h200, 1'b0, 32'd0, 1'b0);
        vectors++;
        if (x_err !== 1'b1 || x_rdata !== 32'd0 || x_waits != EXP_WAITS) begin
            miscompares++;
            $display("FAIL unmapped_read got err=%b rd=%h waits=%0d exp 1 0 %0d", x_err, x_rdata, x_waits, EXP_WAITS);
        end
        apb_xfer(32'h000, 1'b1, 32'h1234_5678, 1'b0);
        vectors++;
        if (x_err !== 1'b1 || x_rdata !== 32'd0) begin
            miscompares++;
            $display("FAIL ver_write got err=%b rd=%h exp 1 0", x_err, x_rdata);
        end
        apb_xfer(32'h000, 1'b0, 32'd0, 1'b0);
        vectors++;
        if (x_rdata !== 32'h0001_2024) begin
            miscompares++;
            $display("FAIL ver_after_write got %h exp 00012024", x_rdata);
        end
    endtask

    task automatic test_back_to_back();
        done = 1'b1;
        apb_xfer(32'h104, 1'b1, 32'hCAFE_0001, 1'b1);
        apb_xfer(32'h104, 1'b0, 32'd0, 1'b1);
        m_dst = 32'hCAFE_0001;
        vectors++;
        if (x_rdata !== 32'hCAFE_0001 || x_err !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_read got %h err=%b exp cafe0001 0", x_rdata, x_err);
        end
        apb_xfer(32'h108, 1'b1, 32'hFFFF_ABCD, 1'b0);
        m_len = 16'hABCD;
        apb_xfer(32'h108, 1'b0, 32'd0, 1'b0);
        vectors++;
        if (x_rdata !== 32'h0000_ABCD) begin
            miscompares++;
            $display("FAIL b2b_len_upper got %h exp 0000abcd", x_rdata);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 32'h104; pwrite = 1'b1; pwdata = 32'h55;
        @(posedge clk); #1;
        penable = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'd0) begin
            miscompares++;
            $display("FAIL midreset_bus got rdy=%b err=%b rd=%h exp 0 0 0", pready, pslverr, prdata);
        end
        psel = 1'b0; penable = 1'b0; rst = 1'b0;
        m_src = 0; m_dst = 0; m_len = 0;
        @(posedge clk); #1;
        vectors++;
        if (dst_addr !== 32'd0 || src_addr !== 32'd0) begin
            miscompares++;
            $display("FAIL midreset_dst got dst=%h src=%h exp 0 0", dst_addr, src_addr);
        end
        apb_xfer(32'h104, 1'b0, 32'd0, 1'b0);
        vectors++;
        if (x_rdata !== 32'd0 || x_err !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_read got %h err=%b exp 0 0", x_rdata, x_err);
        end
    endtask

    task automatic test_random();
        logic [11:0] offs [8];
        logic [31:0] r, addr, wdata, e_rd;
        logic        wr, e_err, e_start;
        offs[0] = 12'h000; offs[1] = 12'h100; offs[2] = 12'h104; offs[3] = 12'h108;
        offs[4] = 12'h10C; offs[5] = 12'h110; offs[6] = 12'h200; offs[7] = 12'h0FC;
        for (int i = 0; i < 80; i++) begin
            r     = $urandom;
            addr  = {r[31:12], offs[$urandom_range(0, 7)]};
            wr    = 1'($urandom_range(0, 1));
            wdata = $urandom;
            done  = ($urandom_range(0, 3) != 0);
            model(addr, wr, wdata, done, e_rd, e_err, e_start);
            apb_xfer(addr, wr, wdata, 1'($urandom_range(0, 1)));
            vectors++;
            if (x_rdata !== e_rd || x_err !== e_err) begin
                miscompares++;
                $display("FAIL rand%0d_resp addr=%h wr=%b got rd=%h err=%b exp rd=%h err=%b",
                         i, addr, wr, x_rdata, x_err, e_rd, e_err);
            end
            vectors++;
            if (x_start_pre !== 1'b0 || x_start_post !== e_start || x_waits != EXP_WAITS) begin
                miscompares++;
                $display("FAIL rand%0d_start got pre=%b post=%b waits=%0d exp 0 %b %0d",
                         i, x_start_pre, x_start_post, x_waits, e_start, EXP_WAITS);
            end
            vectors++;
            if (src_addr !== m_src || dst_addr !== m_dst || byte_len !== m_len) begin
                miscompares++;
                $display("FAIL rand%0d_regs got %h %h %h exp %h %h %h",
                         i, src_addr, dst_addr, byte_len, m_src, m_dst, m_len);
            end
        end
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        psel = 1'b0; penable = 1'b0; paddr = 32'd0; pwrite = 1'b0; pwdata = 32'd0;
        done = 1'b1; rst = 1'b1;
        test_reset();
        test_rw();
        test_cmd();
        test_busy();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
